// File: rtl/bidir_bus_arbiter_pkg.sv
// bidir_bus_arbiter_pkg: state encodings and buffer direction constants shared by the arbiter
package bidir_bus_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURN  = 2'd1,
        OWN_A = 2'd2,
        OWN_B = 2'd3
    } state_t;
    localparam logic DIR_A2B = 1'b0;
    localparam logic DIR_B2A = 1'b1;
endpackage

// File: rtl/bidir_bus_arbiter_if.sv
// bidir_bus_arbiter_if: request/grant and buffer control bundle between requesters and the arbiter
interface bidir_bus_arbiter_if;
    logic req_a, req_b, gnt_a, gnt_b, oe_a, oe_b, ctrl, busy;
    modport master(input req_a, req_b, output gnt_a, gnt_b, oe_a, oe_b, ctrl, busy);
    modport slave(output req_a, req_b, input gnt_a, gnt_b, oe_a, oe_b, ctrl, busy);
endinterface

// File: rtl/bidir_bus_arbiter_counter.sv
// arb_cycle_counter: loadable up-counter that saturates at LIM and flags reaching it
module arb_cycle_counter #(
    parameter int W = 8,
    parameter int LIM = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic inc,
    output logic done
);
    logic [W-1:0] cnt;
    assign done = cnt == W'(LIM);
    always_ff @(posedge clk)
        cnt <= rst ? '0 : load ? W'(1) : (inc && !done) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/bidir_bus_arbiter.sv
// bidir_bus_arbiter: grants a shared bidirectional buffer to side A or B and
// inserts idle turnaround cycles whenever the buffer direction changes.
module bidir_bus_arbiter
    import bidir_bus_arbiter_pkg::*;
#(
    parameter int TURN_CYCLES = 1,
    parameter int MAX_HOLD = 8
) (
    input logic clk,
    input logic rst,
    bidir_bus_arbiter_if.master bus
);
    state_t state, state_n;
    logic ctrl, ctrl_n, last, last_n;
    logic turn_load, turn_done, hold_load, hold_done;
    logic own, side, my_req, other_req, dir_req, tgt;

    assign own = state == OWN_A || state == OWN_B;
    assign side = state == OWN_B;
    assign my_req = side ? bus.req_b : bus.req_a;
    assign other_req = side ? bus.req_a : bus.req_b;
    assign dir_req = ctrl ? bus.req_b : bus.req_a;
    // On a tie the side that did not release last wins
    assign tgt = (bus.req_a && bus.req_b) ? ~last : bus.req_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ctrl <= DIR_A2B;
            last <= DIR_B2A;
        end else begin
            state <= state_n;
            ctrl <= ctrl_n;
            last <= last_n;
        end
    end

    always_comb begin
        state_n = state;
        ctrl_n = ctrl;
        last_n = last;
        turn_load = 1'b0;
        hold_load = 1'b0;
        case (state)
            IDLE: if (bus.req_a || bus.req_b) begin
                if (tgt == ctrl) begin
                    state_n = tgt ? OWN_B : OWN_A;
                    hold_load = 1'b1;
                end else begin
                    state_n = TURN;
                    ctrl_n = tgt;
                    turn_load = 1'b1;
                end
            end
            TURN: if (turn_done) begin
                state_n = dir_req ? (ctrl ? OWN_B : OWN_A) : IDLE;
                hold_load = dir_req;
            end
            default: if (!my_req || (hold_done && other_req)) begin
                last_n = side;
                state_n = other_req ? TURN : IDLE;
                ctrl_n = other_req ? ~side : ctrl;
                turn_load = other_req;
            end else begin
                hold_load = hold_done;
            end
        endcase
    end

    arb_cycle_counter #(.W(4), .LIM(TURN_CYCLES)) u_turn (
        .clk(clk), .rst(rst), .load(turn_load), .inc(state == TURN), .done(turn_done)
    );

    arb_cycle_counter #(.W(8), .LIM(MAX_HOLD)) u_hold (
        .clk(clk), .rst(rst), .load(hold_load), .inc(own), .done(hold_done)
    );

    assign bus.gnt_a = state == OWN_A;
    assign bus.gnt_b = state == OWN_B;
    assign bus.oe_a = state == OWN_A;
    assign bus.oe_b = state == OWN_B;
    assign bus.ctrl = ctrl;
    assign bus.busy = state != IDLE;
endmodule
